// File: rtl/spi_tx_queue_if.sv
// Signal bundle around spi_tx_queue: host write side, SPI_MASTER side and status.
// slave is the queue itself; master is whatever surrounds it (host logic plus the SPI master).
interface spi_tx_queue_if #(
    parameter int M = 9
);
    // Write side: a word is taken on every rising edge where wr_en=1 and full=0;
    // wr_en while full is dropped. rx_vld is a one-cycle strobe with no back-pressure.
    logic         wr_en;
    logic [M-1:0] wr_dat;
    logic         full;
    logic         st;
    logic [M-1:0] MTX_DAT;
    logic         LOAD;
    logic [M-1:0] MRX_DAT;
    logic [M-1:0] rx_dat;
    logic         rx_vld;
    logic         busy;
    logic         err_timeout;
    logic [2:0]   dbg_state;

    modport slave (
        input  wr_en, wr_dat, LOAD, MRX_DAT,
        output full, st, MTX_DAT, rx_dat, rx_vld, busy, err_timeout, dbg_state
    );

    modport master (
        output wr_en, wr_dat, LOAD, MRX_DAT,
        input  full, st, MTX_DAT, rx_dat, rx_vld, busy, err_timeout, dbg_state
    );
endinterface

// File: rtl/spi_tx_queue.sv
// TX word queue in front of SPI_MASTER: buffers words, issues st per word,
// waits for the frame (LOAD low then high) and captures the received word.
module spi_tx_queue #(
    parameter int M       = 9,
    parameter int DEPTH   = 4,
    parameter int ST_LEN  = 3,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          rst,
    spi_tx_queue_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (ST_LEN > 1) ? $clog2(ST_LEN) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        WAIT_LO = 3'd2,
        WAIT_HI = 3'd3,
        CAPTURE = 3'd4
    } state_t;

    logic [M-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full_int;
    logic          push;
    logic          pop;

    state_t        state;
    logic [SW-1:0] st_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          load_q;
    logic          load_rise;
    logic          tmo_hit;

    logic          st_q;
    logic [M-1:0]  mtx_q;
    logic [M-1:0]  rx_dat_q;
    logic          rx_vld_q;
    logic          err_q;

    assign full_int  = (count == CW'(DEPTH));
    assign push      = bus.wr_en && !full_int;
    // Popping only from IDLE with the master idle guarantees one word per frame.
    assign pop       = (state == IDLE) && (count != '0) && bus.LOAD;
    assign load_rise = bus.LOAD && !load_q;
    assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // tmo_cnt is cleared on every state change, so it measures time spent in the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            st_q     <= 1'b0;
            mtx_q    <= '0;
            rx_dat_q <= '0;
            rx_vld_q <= 1'b0;
            err_q    <= 1'b0;
            st_cnt   <= '0;
            tmo_cnt  <= '0;
            load_q   <= 1'b1;
        end else begin
            load_q   <= bus.LOAD;
            rx_vld_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        mtx_q   <= mem[rd_ptr];
                        st_q    <= 1'b1;
                        st_cnt  <= '0;
                        tmo_cnt <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    if (st_cnt == SW'(ST_LEN - 1)) begin
                        st_q    <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= WAIT_LO;
                    end else begin
                        st_cnt <= st_cnt + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!bus.LOAD) begin
                        tmo_cnt <= '0;
                        state   <= WAIT_HI;
                    end else if (tmo_hit) begin
                        err_q   <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WAIT_HI: begin
                    // The master presents MRX_DAT by the time LOAD returns high.
                    if (load_rise) begin
                        rx_dat_q <= bus.MRX_DAT;
                        rx_vld_q <= 1'b1;
                        tmo_cnt  <= '0;
                        state    <= CAPTURE;
                    end else if (tmo_hit) begin
                        err_q   <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    tmo_cnt <= '0;
                    state   <= IDLE;
                end
                default: begin
                    st_q    <= 1'b0;
                    tmo_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.full        = full_int;
    assign bus.st          = st_q;
    assign bus.MTX_DAT     = mtx_q;
    assign bus.rx_dat      = rx_dat_q;
    assign bus.rx_vld      = rx_vld_q;
    assign bus.busy        = (state != IDLE);
    assign bus.err_timeout = err_q;
    assign bus.dbg_state   = state;
endmodule
